// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 turn controller.
// Holds the sequencing state enum, default board geometry and encodings.
package connect4_pkg;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;

  localparam logic [2:0] NO_COL = 3'd7;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WRITE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_DRAW    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/col_height_tracker.sv
// Per-column fill heights for the Connect-4 board, saturating at ROWS.
// One combinational read port and a single increment strobe.
module col_height_tracker
  import connect4_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_rd_col,
  output logic [2:0] o_height,
  output logic       o_full,
  input  logic       i_inc,
  input  logic [2:0] i_inc_col
);

  localparam logic [2:0] ROWS3 = ROWS[2:0];
  localparam logic [2:0] COLS3 = COLS[2:0];

  logic [2:0] r_height [COLS];

  // Height counters: cleared on reset, bumped by one accepted write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) begin
        r_height[i] <= 3'd0;
      end
    end else begin
      if (i_inc && (i_inc_col < COLS3) && (r_height[i_inc_col] != ROWS3)) begin
        r_height[i_inc_col] <= r_height[i_inc_col] + 3'd1;
      end
    end
  end

  // Out-of-range columns read as full so they can never be written
  always_comb begin
    o_height = ROWS3;
    if (i_rd_col < COLS3) begin
      o_height = r_height[i_rd_col];
    end else begin
      o_height = ROWS3;
    end
    o_full = (o_height == ROWS3);
  end

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 game sequencer: accepts drops, checks column height, issues one
// board write per move, resets the column selector and passes the turn.
module connect4_turn_ctrl
  import connect4_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colval,
  input  logic       drop,
  input  logic       game_over,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic       wr_player,
  output logic       player,
  output logic       col_rst_n,
  output logic       col_full,
  output logic       board_full,
  output logic       busy
);

  localparam logic [2:0] COLS3 = COLS[2:0];
  localparam logic [5:0] CELLS = 6'(ROWS * COLS);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_col_latch;
  logic [5:0] r_move_cnt;
  logic       r_player;
  logic [2:0] w_height;
  logic       w_full;
  logic       w_accept;

  assign w_accept = drop && (colval != NO_COL) && (colval < COLS3);
  assign player   = r_player;

  col_height_tracker #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_heights (
    .clk       (clk),
    .rst       (rst),
    .i_rd_col  (r_col_latch),
    .o_height  (w_height),
    .o_full    (w_full),
    .i_inc     (r_state == S_WRITE),
    .i_inc_col (r_col_latch)
  );

  // State, latched column, move count and turn owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_col_latch <= 3'd0;
      r_move_cnt  <= 6'd0;
      r_player    <= P1;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && !game_over && w_accept) begin
        r_col_latch <= colval;
      end
      if (r_state == S_WRITE) begin
        r_move_cnt <= r_move_cnt + 6'd1;
      end
      if (r_state == S_ADVANCE) begin
        r_player <= ~r_player;
      end
    end
  end

  // Next state; game_over wins over a simultaneous drop in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (game_over) begin
          w_next_state = S_DONE;
        end else if (w_accept) begin
          w_next_state = S_CHECK;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CHECK: begin
        if (w_full) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: w_next_state = S_ADVANCE;
      S_ADVANCE: begin
        if (r_move_cnt == CELLS) begin
          w_next_state = S_DRAW;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DRAW:  w_next_state = S_DRAW;
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    wr_en      = 1'b0;
    wr_row     = 3'd0;
    wr_col     = 3'd0;
    wr_player  = 1'b0;
    col_full   = 1'b0;
    col_rst_n  = 1'b1;
    board_full = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_CHECK: col_full = w_full;
      S_WRITE: begin
        wr_en     = 1'b1;
        wr_row    = w_height;
        wr_col    = r_col_latch;
        wr_player = r_player;
      end
      S_ADVANCE: col_rst_n  = 1'b0;
      S_DRAW:    board_full = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Scoreboard bench for connect4_turn_ctrl: a board-level game model predicts
// each write / full-column reject; a monitor process pops and compares.
module tb_connect4_turn_ctrl;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] colval = 3'd7;
  logic       drop = 1'b0;
  logic       game_over = 1'b0;
  logic       wr_en, wr_player, player, col_rst_n, col_full, board_full, busy;
  logic [2:0] wr_row, wr_col;

  connect4_turn_ctrl dut (
    .clk(clk), .rst(rst), .colval(colval), .drop(drop), .game_over(game_over),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_player(wr_player),
    .player(player), .col_rst_n(col_rst_n), .col_full(col_full),
    .board_full(board_full), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_full;
    int row;
    int col;
    int pl;
    int cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // Game model: column heights, whose turn, move count, mode (0 play, 1 draw, 2 done)
  int h[7];
  int m_player;
  int m_moves;
  int m_mode;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 7; i++) h[i] = 0;
    m_player = 0;
    m_moves  = 0;
    m_mode   = 0;
  endtask

  task automatic monitor();
    exp_t e;
    bit   prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_wr = 1'b0;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("missed_output", 0, 1);
        end
        if (wr_en || col_full) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_kind_colfull", int'(col_full), int'(e.is_full));
            chk("out_cycle", cyc, e.cyc);
            if (e.is_full) begin
              chk("colfull_no_wr", int'(wr_en), 0);
            end else begin
              chk("wr_row", int'(wr_row), e.row);
              chk("wr_col", int'(wr_col), e.col);
              chk("wr_player", int'(wr_player), e.pl);
            end
          end
        end else begin
          chk("idle_wr_bus", int'({wr_row, wr_col, wr_player}), 0);
        end
        chk("col_rst_n", int'(col_rst_n), prev_wr ? 0 : 1);
        prev_wr = wr_en;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    drop = 1'b0;
    game_over = 1'b0;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_col_full", int'(col_full), 0);
    chk("rst_col_rst_n", int'(col_rst_n), 1);
    chk("rst_board_full", int'(board_full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_player", int'(player), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    chk("queue_empty_at_reset", q.size(), 0);
    q.delete();
    model_clear();
  endtask

  // One drop attempt; optional extra drop while busy, game_over with drop, or game_over mid-move
  task automatic do_move(input int col, input bit extra, input bit go_now, input bit go_mid);
    int   c;
    bit   acc;
    exp_t e;
    @(posedge clk);
    #1;
    c   = cyc;
    acc = (m_mode == 0) && !go_now && (col < 7) && (h[col] < 6);
    if (m_mode == 0) begin
      if (go_now) begin
        m_mode = 2;
      end else if (col < 7) begin
        e.col = col;
        e.pl  = m_player;
        e.row = h[col];
        if (h[col] == 6) begin
          e.is_full = 1'b1;
          e.cyc     = c + 1;
        end else begin
          e.is_full = 1'b0;
          e.cyc     = c + 2;
          h[col]++;
          m_moves++;
          m_player ^= 1;
          if (m_moves == 42) m_mode = 1;
        end
        q.push_back(e);
      end
      if (go_mid && m_mode == 0) m_mode = 2;
    end
    colval = 3'(col);
    drop   = 1'b1;
    if (go_now) game_over = 1'b1;
    @(posedge clk);
    #1;
    drop   = 1'b0;
    colval = 3'($urandom_range(0, 7));
    if (go_mid) game_over = 1'b1;
    if (extra && acc) begin
      drop   = 1'b1;
      colval = 3'($urandom_range(0, 6));
    end
    @(posedge clk);
    #1;
    drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_busy", int'(busy), (m_mode != 0) ? 1 : 0);
    chk("post_player", int'(player), m_player);
    chk("post_board_full", int'(board_full), (m_mode == 1) ? 1 : 0);
  endtask

  initial begin
    model_clear();
    fork
      monitor();
    join_none

    // First move lands at row 0 of column 3 for P1
    do_reset();
    do_move(3, 0, 0, 0);

    // Six into column 0, then a rejected seventh
    do_reset();
    for (int i = 0; i < 7; i++) do_move(0, 0, 0, 0);
    do_move(7, 0, 0, 0);
    do_move(1, 1, 0, 0);
    do_move(1, 1, 0, 0);

    // game_over with drop, then game_over raised mid-move
    do_reset();
    do_move(4, 0, 1, 0);
    do_move(4, 0, 0, 0);
    do_reset();
    do_move(5, 0, 0, 1);
    do_move(5, 0, 0, 0);

    // Reset while the write strobe is up
    do_reset();
    do_move(2, 0, 0, 0);
    do_move(2, 0, 0, 0);
    @(posedge clk);
    #1;
    colval = 3'd2;
    drop   = 1'b1;
    @(posedge clk);
    #1;
    drop = 1'b0;
    @(posedge clk);
    #1;
    chk("midwr_wr_en", int'(wr_en), 1);
    chk("midwr_wr_row", int'(wr_row), 2);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_player", int'(player), 0);
    chk("abort_col_rst_n", int'(col_rst_n), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_clear();
    do_move(2, 0, 0, 0);

    // Fill the whole board to a draw, then confirm drops are ignored
    do_reset();
    for (int i = 0; i < 42; i++) do_move(i / 6, 0, 0, 0);
    do_move(1, 0, 0, 0);
    do_move(6, 0, 0, 0);

    // Random play
    do_reset();
    repeat (50) do_move($urandom_range(0, 7), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    do_move($urandom_range(0, 6), 1'b0, 1'b0, 1'b1);
    do_move($urandom_range(0, 6), 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/connect4_turn_ctrl.md
# connect4_turn_ctrl

Game-sequencing controller for the Connect-4 datapath. It consumes the column cursor value from the column-select state machine and a debounced drop pulse. It tracks per-column fill height and the current player, and issues single-cycle write commands to the board memory. After every accepted move it resets the column-select state machine and hands the turn to the other player.

## Interface
- ROWS, 6, board rows; row 0 is the bottom.
- COLS, 7, board columns; must be ≤ 7 because colval 7 means "no column selected".
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- colval  in  3  cursor column from the column-select FSM; 7 = none selected.
- drop  in  1  debounced one-cycle drop request.
- game_over  in  1  level from the win checker; freezes play.
- wr_en  out  1  one-cycle board write strobe.
- wr_row  out  3  row to write, valid with wr_en.
- wr_col  out  3  column to write, valid with wr_en.
- wr_player  out  1  piece owner to write (0 = P1, 1 = P2), valid with wr_en.
- player  out  1  player whose turn it is.
- col_rst_n  out  1  active-low one-cycle pulse to FSM_rst of the column-select FSM.
- col_full  out  1  one-cycle pulse: drop rejected because the column is full.
- board_full  out  1  level: all ROWS*COLS cells are used (draw).
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CHECK, WRITE, ADVANCE, DRAW, DONE.
- State and col_latch register on clk; outputs are Moore-decoded from state.
- **IDLE**
  - game_over=1 -> DONE; game_over has priority over drop.
  - drop=1 and colval<COLS -> latch colval into col_latch, go to CHECK.
  - drop with colval ≥ COLS is ignored.
- **CHECK**
  - height[col_latch]==ROWS -> col_full=1 for this cycle, return to IDLE; player unchanged.
  - Otherwise -> WRITE.
- **WRITE**
  - wr_en=1, wr_row=height[col_latch], wr_col=col_latch, wr_player=player.
  - On exit, height[col_latch] is incremented and move_cnt is incremented.
- **ADVANCE**
  - col_rst_n=0; player toggles on exit.
  - move_cnt==ROWS*COLS -> DRAW, else -> IDLE.
- **DRAW**: board_full=1; absorbing until reset.
- **DONE**: absorbing until reset; wr_en is never asserted.
- Storage:
  - height[0..COLS-1] are 3-bit counters, saturating at ROWS.
  - move_cnt is 6-bit.
- Any drop arriving while busy is discarded; there is no queueing.
- Default output values: wr_en=0, col_full=0, col_rst_n=1. wr_row, wr_col and wr_player read 0 when wr_en=0.

## Timing
- Reset values (async, on rst low):
  - state=IDLE, all heights=0, move_cnt=0, player=0.
  - wr_en=0, col_full=0, col_rst_n=1, board_full=0, busy=0.
- Accepted drop sampled at edge k:
  - wr_en high in cycle k+1 → k+2.
  - col_rst_n low in the next cycle.
  - Back in IDLE with player toggled 3 cycles after the drop edge.
- Throughput: one move per 4 cycles minimum.
- Rejected (full column): col_full in the cycle after the drop edge; back in IDLE one cycle later.
- Reset asserted mid-move (e.g. in WRITE) aborts immediately.
  - No wr_en after reset release.
  - All heights cleared.
- game_over rising while busy: the current move completes through ADVANCE. IDLE then goes to DONE on the next edge.
- Drop and game_over both high in IDLE -> DONE; no write.

## Structure
- Package connect4_pkg holds:
  - the state enum;
  - ROWS/COLS default constants;
  - NO_COL = 3'd7;
  - the player encoding P1=0 / P2=1.
- Sub-module col_height_tracker:
  - holds the COLS saturating height counters;
  - provides a read port (col -> height, is_full);
  - has an increment strobe;
  - shares the same clk/rst.
- Top module contains the FSM, move_cnt and player flop.

## Test plan
- Reset, then drop with colval=3 -> wr_en one cycle with row 0, col 3, player 0. col_rst_n low the next cycle, then player=1.
- Six drops into col 0 -> wr_row 0..5 with player alternating 0,1,0,1,0,1. A seventh drop into col 0 -> col_full pulse, no wr_en, player unchanged at 0.
- Drop with colval=7, and a drop while busy -> no wr_en, no state change, busy profile unchanged.
- Fill all 42 cells without game_over -> 42 wr_en strobes. board_full=1 after the last ADVANCE; further drops are ignored.
- game_over=1 together with drop in IDLE -> DONE, no wr_en. Raising game_over during WRITE -> that write completes, then DONE.
- Assert rst low during WRITE -> all outputs at reset values immediately. The next drop into the same column writes row 0.
